des_stream_ctrl: RTL and testbench

DES_STREAM_CTRL -- requirements
Module: des_stream_ctrl

---
 rtl/des_stream_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_des_stream_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_stream_ctrl.sv
// Stream controller feeding an external DES core: input FIFO, one-block-at-a-time issue/wait/output sequencing.
// Optional CBC chaining (chain register, iv load, XOR on issue) is built in only when DES_CBC_EN is defined.
module des_stream_ctrl #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [DATA_W-1:0] raw_data,
    input  logic              data_valid_in,
    output logic              in_ready,
    input  logic              key_valid,
    input  logic              cbc_mode,
    input  logic [DATA_W-1:0] iv,
    input  logic              iv_load,
    output logic [DATA_W-1:0] core_block,
    output logic              core_valid,
    input  logic [DATA_W-1:0] core_result,
    input  logic              core_done,
    output logic [DATA_W-1:0] encrypted_data,
    output logic              data_valid_out,
    input  logic              out_ready,
    output logic              busy,
    output logic              overflow,
    output logic [CNT_W-1:0]  block_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]   OCC_FULL = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   OCC_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t state_q;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    occ_q, occ_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] core_block_q;
    logic              core_valid_q;
    logic [DATA_W-1:0] enc_q;
    logic              dvo_q;
    logic              busy_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              issue_ok;
    logic [DATA_W-1:0] fifo_head;
    logic [DATA_W-1:0] issue_block;

    assign fifo_full  = (occ_q == OCC_FULL);
    assign fifo_empty = (occ_q == '0);
    // Readiness uses the pre-pop occupancy: a full FIFO refuses a push even while popping.
    assign push       = data_valid_in && !fifo_full;
    assign pop        = (state_q == ST_ISSUE) && !fifo_empty;
    assign issue_ok   = key_valid && !fifo_empty;
    assign fifo_head  = mem_q[rd_ptr_q];

    assign wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    assign rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    assign ovf_d    = ovf_q || (data_valid_in && fifo_full);

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= raw_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef DES_CBC_EN
    logic [DATA_W-1:0] chain_q;
    logic [DATA_W-1:0] chain_src;

    // An iv loaded in the same cycle as an IDLE issue must already chain that issue.
    assign chain_src   = (state_q == ST_IDLE && iv_load) ? iv : chain_q;
    assign issue_block = cbc_mode ? (fifo_head ^ chain_src) : fifo_head;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            chain_q <= '0;
        end else if (state_q == ST_IDLE && iv_load) begin
            chain_q <= iv;
        end else if (state_q == ST_WAIT && core_done) begin
            chain_q <= core_result;
        end
    end
`else
    logic unused_cbc;

    assign unused_cbc  = ^{cbc_mode, iv, iv_load};
    assign issue_block = fifo_head;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            core_block_q <= '0;
            core_valid_q <= 1'b0;
            enc_q        <= '0;
            dvo_q        <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            core_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (issue_ok) begin
                        state_q      <= ST_ISSUE;
                        core_valid_q <= 1'b1;
                        core_block_q <= issue_block;
                        busy_q       <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done) begin
                        enc_q   <= core_result;
                        dvo_q   <= 1'b1;
                        state_q <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        cnt_q <= cnt_q + CNT_ONE;
                        dvo_q <= 1'b0;
                        if (issue_ok) begin
                            state_q      <= ST_ISSUE;
                            core_valid_q <= 1'b1;
                            core_block_q <= issue_block;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    dvo_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready       = !fifo_full;
    assign core_block     = core_block_q;
    assign core_valid     = core_valid_q;
    assign encrypted_data = enc_q;
    assign data_valid_out = dvo_q;
    assign busy           = busy_q;
    assign overflow       = ovf_q;
    assign block_count    = cnt_q;

endmodule

// File: tb/tb_des_stream_ctrl.sv
// Bench for des_stream_ctrl: stub DES core (block XOR all-ones, done 3 cycles after valid) and a queue-based reference model.
module tb_des_stream_ctrl;

    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int CW    = 2;
    localparam logic [DW-1:0] ALL1 = {DW{1'b1}};

    logic          clk = 1'b0;
    logic          n_rst;
    logic [DW-1:0] raw_data;
    logic          data_valid_in;
    logic          in_ready;
    logic          key_valid;
    logic          cbc_mode;
    logic [DW-1:0] iv;
    logic          iv_load;
    logic [DW-1:0] core_block;
    logic          core_valid;
    logic [DW-1:0] core_result;
    logic          core_done;
    logic [DW-1:0] encrypted_data;
    logic          data_valid_out;
    logic          out_ready;
    logic          busy;
    logic          overflow;
    logic [CW-1:0] block_count;

    always #5 clk = ~clk;

    des_stream_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .n_rst(n_rst),
        .raw_data(raw_data), .data_valid_in(data_valid_in), .in_ready(in_ready),
        .key_valid(key_valid), .cbc_mode(cbc_mode), .iv(iv), .iv_load(iv_load),
        .core_block(core_block), .core_valid(core_valid),
        .core_result(core_result), .core_done(core_done),
        .encrypted_data(encrypted_data), .data_valid_out(data_valid_out), .out_ready(out_ready),
        .busy(busy), .overflow(overflow), .block_count(block_count)
    );

    // Stub core: not reset, so a block issued before a reset still produces a late done.
    logic [2:0]    v_pipe = '0;
    logic [DW-1:0] b_pipe [3];
    always @(posedge clk) begin
        v_pipe    <= {v_pipe[1:0], core_valid};
        b_pipe[0] <= core_block;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign core_done   = v_pipe[2];
    assign core_result = b_pipe[2] ^ ALL1;

    // Reference model state
    logic [DW-1:0] q_in [$];
    logic [DW-1:0] q_res [$];
    logic [DW-1:0] cb_log [$];
    logic [CW-1:0] seq_q [$];
    logic [DW-1:0] m_chain;
    logic [DW-1:0] data_prev;
    int            m_cnt;
    bit            m_ovf;
    bit            hold_prev;
    int            n_out, n_cv, n_acc;
    int            checks, failures;
    int            exp_seq [5] = '{1, 2, 3, 0, 1};

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of model update and checking; called at the sample point, returns at the next one.
    task automatic cycle();
        bit            exp_rdy;
        bit            hs;
        bit            cbc_eff;
        logic [DW-1:0] exp_cb;
`ifdef DES_CBC_EN
        cbc_eff = cbc_mode;
`else
        cbc_eff = 1'b0;
`endif
        exp_rdy = (q_in.size() != DEPTH);
        chk("in_ready", in_ready, exp_rdy);
        chk("overflow", overflow, m_ovf);
        chk("block_count", block_count, m_cnt);
        if (hold_prev) begin
            chk("hold_valid", data_valid_out, 1);
            chk("hold_data", encrypted_data, data_prev);
        end
        if (q_res.size() == 0) chk("no_spurious_out", data_valid_out, 0);
        if (core_valid || data_valid_out) chk("busy", busy, 1);
        if (iv_load) m_chain = iv;
        if (core_valid) begin
            n_cv++;
            if (q_in.size() == 0) begin
                chk("issue_nonempty", core_valid, 0);
            end else begin
                exp_cb = q_in.pop_front();
                if (cbc_eff) exp_cb = exp_cb ^ m_chain;
                chk("core_block", core_block, exp_cb);
                cb_log.push_back(core_block);
                m_chain = exp_cb ^ ALL1;
                q_res.push_back(exp_cb ^ ALL1);
            end
        end
        if (data_valid_in) begin
            if (exp_rdy) begin
                q_in.push_back(raw_data);
                n_acc++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        hs = data_valid_out && out_ready && (q_res.size() != 0);
        if (hs) begin
            chk("enc_data", encrypted_data, q_res.pop_front());
            n_out++;
            m_cnt = (m_cnt + 1) % (1 << CW);
        end
        hold_prev = data_valid_out && !out_ready;
        data_prev = encrypted_data;
        @(posedge clk);
        #1;
        if (hs) seq_q.push_back(block_count);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic push1(input logic [DW-1:0] d);
        raw_data      = d;
        data_valid_in = 1'b1;
        cycle();
        data_valid_in = 1'b0;
    endtask

    task automatic do_reset();
        data_valid_in = 1'b0;
        iv_load       = 1'b0;
        n_rst         = 1'b0;
        #1;
        chk("rst_core_block", core_block, 0);
        chk("rst_core_valid", core_valid, 0);
        chk("rst_enc", encrypted_data, 0);
        chk("rst_dvo", data_valid_out, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", block_count, 0);
        q_in.delete();
        q_res.delete();
        m_chain   = '0;
        m_cnt     = 0;
        m_ovf     = 1'b0;
        hold_prev = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
    endtask

    initial begin
        int            lat, t, base, cv0, acc0, n_dvo;
        logic [DW-1:0] bp_data;
        checks = 0; failures = 0; n_out = 0; n_cv = 0; n_acc = 0;
        n_rst = 1'b0; raw_data = '0; data_valid_in = 1'b0; key_valid = 1'b0;
        cbc_mode = 1'b0; iv = '0; iv_load = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // ECB single block with latency and one-cycle output
        key_valid = 1'b1; out_ready = 1'b1;
        push1(64'h0123456789ABCDEF);
        lat = 1;
        while (!data_valid_out && lat < 30) begin
            cycle();
            lat++;
        end
        chk("ecb_latency", lat, 6);
        chk("ecb_data", encrypted_data, 64'hFEDCBA9876543210);
        n_dvo = 0;
        repeat (6) begin
            n_dvo += int'(data_valid_out);
            cycle();
        end
        chk("ecb_dvo_cycles", n_dvo, 1);
        chk("ecb_count", block_count, 1);

        // Overflow: fill with issue blocked, fifth push dropped
        do_reset();
        key_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push1({$urandom, $urandom});
            if (i == 3) chk("ovf_full_ready", in_ready, 0);
        end
        chk("ovf_flag", overflow, 1);
        base = n_out;
        key_valid = 1'b1;
        run(40);
        chk("ovf_outputs", n_out - base, 4);
        chk("ovf_sticky", overflow, 1);

        // Backpressure: output held for 10 cycles, no further issue
        do_reset();
        key_valid = 1'b1; out_ready = 1'b0;
        push1({$urandom, $urandom});
        push1({$urandom, $urandom});
        t = 0;
        while (!data_valid_out && t < 30) begin
            cycle();
            t++;
        end
        chk("bp_reach_out", data_valid_out, 1);
        cv0 = n_cv;
        bp_data = encrypted_data;
        run(10);
        chk("bp_no_issue", n_cv - cv0, 0);
        chk("bp_held", data_valid_out, 1);
        chk("bp_data", encrypted_data, bp_data);
        base = n_out;
        out_ready = 1'b1;
        run(20);
        chk("bp_released", n_out - base, 2);

        // Reset while waiting on the core; the late done must be ignored
        do_reset();
        key_valid = 1'b1; out_ready = 1'b1;
        push1({$urandom, $urandom});
        t = 0;
        while (!core_valid && t < 10) begin
            cycle();
            t++;
        end
        chk("rw_issue", core_valid, 1);
        cycle();
        chk("rw_busy", busy, 1);
        base = n_out;
        do_reset();
        run(10);
        chk("rw_no_out", n_out - base, 0);
        chk("rw_count", block_count, 0);

        // Counter wrap with CNT_W=2
        do_reset();
        key_valid = 1'b1; out_ready = 1'b1;
        seq_q.delete();
        for (int i = 0; i < 5; i++) begin
            push1({$urandom, $urandom});
            run(9);
        end
        chk("wrap_seq_len", seq_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < seq_q.size()) chk($sformatf("wrap_seq%0d", i), seq_q[i], exp_seq[i]);
        end

        // Chaining: iv=1, two zero blocks (plain ECB when CBC is not built in)
        do_reset();
        key_valid = 1'b0; out_ready = 1'b1; cbc_mode = 1'b1;
        iv = 64'h1; iv_load = 1'b1;
        cycle();
        iv_load = 1'b0;
        cb_log.delete();
        push1(64'h0);
        push1(64'h0);
        key_valid = 1'b1;
        run(25);
        chk("cbc_issues", cb_log.size(), 2);
        if (cb_log.size() == 2) begin
`ifdef DES_CBC_EN
            chk("cbc_blk0", cb_log[0], 64'h1);
            chk("cbc_blk1", cb_log[1], 64'hFFFF_FFFF_FFFF_FFFE);
`else
            chk("ecb_blk0", cb_log[0], 64'h0);
            chk("ecb_blk1", cb_log[1], 64'h0);
`endif
        end
        cbc_mode = 1'b0;

        // Random traffic against the model
        do_reset();
        base = n_out;
        acc0 = n_acc;
        for (int i = 0; i < 400; i++) begin
            key_valid     = ($urandom_range(0, 7) != 0);
            out_ready     = ($urandom_range(0, 1) == 1);
            data_valid_in = ($urandom_range(0, 2) == 0);
            raw_data      = {$urandom, $urandom};
            cycle();
        end
        data_valid_in = 1'b0; key_valid = 1'b1; out_ready = 1'b1;
        run(60);
        chk("rand_all_out", n_out - base, n_acc - acc0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
